// File: rtl/nou_arb_pkg.sv
// Shared types for the NOU round-robin burst arbiter.
package nou_arb_pkg;

   // Arbiter FSM: IDLE picks the next source, BURST pops beats from it.
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

endpackage : nou_arb_pkg

// File: rtl/fwft_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scan offsets from farthest to nearest so the nearest hit overwrites the others.
   always_comb begin
      int c;
      // NOTE: every output gets a default before the loop, otherwise an
      // unmatched path would hold the old value and infer a latch.
      found = 1'b0;
      idx   = '0;
      c     = 0;
      for (int i = N - 1; i >= 0; i--) begin
         c = int'(ptr) + i;
         if (c >= N) c = c - N;
         if (req[c]) begin
            found = 1'b1;
            idx   = W'(c);
         end
      end
   end

endmodule : rr_pick

// File: rtl/fwft_rr_arbiter.sv
// Round-robin burst arbiter: shares one valid/ready consumer among NUM_SRC
// FWFT read ports, popping up to MAX_BURST beats per grant before rotating.
module fwft_rr_arbiter
   import nou_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int WIDTH     = 512,
   parameter int MAX_BURST = 8,
   localparam int SRC_W    = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SRC-1:0]       src_empty_i,
   input  logic [NUM_SRC*WIDTH-1:0] src_dout_i,
   output logic [NUM_SRC-1:0]       src_rd_en_o,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [WIDTH-1:0]         m_data_o,
   output logic [SRC_W-1:0]         m_src_o,
   output logic                     m_last_o,
   output logic                     busy_o
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   arb_state_t       state, state_next;
   logic [SRC_W-1:0] ptr, ptr_next;
   logic [SRC_W-1:0] grant, grant_next;
   logic [CNT_W-1:0] beat_cnt, beat_next;
   logic [SRC_W-1:0] grant_wrap;
   logic [SRC_W-1:0] pick_idx;
   logic             pick_found;
   logic             last_beat;
   logic             pop;
   logic [WIDTH-1:0] head_data;

   rr_pick #(
      .N (NUM_SRC),
      .W (SRC_W)
   ) u_pick (
      .req   (~src_empty_i),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign busy_o     = (state == ARB_BURST);
   assign last_beat  = (beat_cnt == CNT_W'(MAX_BURST - 1));
   assign grant_wrap = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;

   // A pop needs a granted non-empty source and a free (or draining) output slot.
   assign pop = !rst && (state == ARB_BURST) && !src_empty_i[grant] &&
                (!m_valid_o || m_ready_i);

   // Drive the read enable of the granted source only.
   always_comb begin
      src_rd_en_o = '0;
      if (pop) src_rd_en_o[grant] = 1'b1;
   end

   // Select the head beat of the granted source.
   always_comb begin
      head_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SRC_W'(i)) head_data = src_dout_i[i*WIDTH +: WIDTH];
      end
   end

   // Next-state logic: pick in IDLE, count beats and decide when to rotate in BURST.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      grant_next = grant;
      beat_next  = beat_cnt;
      case (state)
         ARB_IDLE: begin
            if (pick_found) begin
               grant_next = pick_idx;
               beat_next  = '0;
               state_next = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (pop) begin
               beat_next = beat_cnt + 1'b1;
               if (last_beat) begin
                  state_next = ARB_IDLE;
                  ptr_next   = grant_wrap;
               end
            end else if (src_empty_i[grant]) begin
               // Source ran dry: end the grant early and rotate.
               state_next = ARB_IDLE;
               ptr_next   = grant_wrap;
            end
         end
      endcase
   end

   // FSM, pointer, grant and beat counter registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      if (rst) begin
         state    <= ARB_IDLE;
         ptr      <= '0;
         grant    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         grant    <= grant_next;
         beat_cnt <= beat_next;
      end
   end

   // Output register: load on pop, clear valid once accepted, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_src_o   <= '0;
         m_last_o  <= 1'b0;
      end else if (pop) begin
         m_valid_o <= 1'b1;
         m_data_o  <= head_data;
         m_src_o   <= grant;
         m_last_o  <= last_beat;
      end else if (m_valid_o && m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

endmodule : fwft_rr_arbiter
